// File: rtl/rng_sample_checker.sv
// rng_sample_checker: drives a signed-range random generator for a programmed
// number of samples, captures each sample one cycle after its enable, and
// reports range violations, stuck runs and the observed extremes.
module rng_sample_checker #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 16,
    parameter int STUCK_LIMIT = 4
) (
    input  logic                          in_clock,
    input  logic                          in_reset,
    input  logic                          in_start,
    input  logic signed [WIDTH-1:0]       in_min,
    input  logic signed [WIDTH-1:0]       in_max,
    input  logic        [COUNT_WIDTH-1:0] in_count,
    input  logic signed [WIDTH-1:0]       in_random,
    output logic                          out_enable,
    output logic                          out_busy,
    output logic                          out_done,
    output logic        [COUNT_WIDTH-1:0] out_range_errors,
    output logic                          out_stuck,
    output logic signed [WIDTH-1:0]       out_min_seen,
    output logic signed [WIDTH-1:0]       out_max_seen,
    output logic        [COUNT_WIDTH-1:0] out_samples
);

    localparam int RUN_W = $clog2(STUCK_LIMIT + 1);
    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   issue_q, issue_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic signed [WIDTH-1:0]  min_q, min_d;
    logic signed [WIDTH-1:0]  max_q, max_d;
    logic                     sample_valid_q;
    logic                     start_acc;

    logic [COUNT_WIDTH-1:0]   range_errors_q, range_errors_d;
    logic [COUNT_WIDTH-1:0]   samples_q, samples_d;
    logic                     stuck_q, stuck_d;
    logic signed [WIDTH-1:0]  min_seen_q, min_seen_d;
    logic signed [WIDTH-1:0]  max_seen_q, max_seen_d;
    logic signed [WIDTH-1:0]  prev_q, prev_d;
    logic [RUN_W-1:0]         run_len_q, run_len_d;

    // Sequencer: next state, issue counter, latched run parameters and handshake outputs
    always_comb begin
        state_d    = state_q;
        issue_d    = issue_q;
        count_d    = count_q;
        min_d      = min_q;
        max_d      = max_q;
        out_enable = 1'b0;
        out_busy   = 1'b0;
        out_done   = 1'b0;
        start_acc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    start_acc = 1'b1;
                    count_d   = in_count;
                    min_d     = in_min;
                    max_d     = in_max;
                    issue_d   = '0;
                    state_d   = (in_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                out_enable = 1'b1;
                out_busy   = 1'b1;
                issue_d    = issue_q + COUNT_WIDTH'(1);
                if (issue_d == count_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // last enable's sample is captured at the end of this cycle
                out_busy = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                out_busy = 1'b1;
                out_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result datapath: clear on accepted start, otherwise fold in each captured sample
    always_comb begin
        range_errors_d = range_errors_q;
        samples_d      = samples_q;
        stuck_d        = stuck_q;
        min_seen_d     = min_seen_q;
        max_seen_d     = max_seen_q;
        prev_d         = prev_q;
        run_len_d      = run_len_q;
        if (start_acc) begin
            range_errors_d = '0;
            samples_d      = '0;
            stuck_d        = 1'b0;
            run_len_d      = '0;
            min_seen_d     = SMAX;
            max_seen_d     = SMIN;
        end else if (sample_valid_q) begin
            samples_d = samples_q + COUNT_WIDTH'(1);
            if ((in_random < min_q || in_random > max_q) && !(&range_errors_q))
                range_errors_d = range_errors_q + COUNT_WIDTH'(1);
            if (in_random < min_seen_q) min_seen_d = in_random;
            if (in_random > max_seen_q) max_seen_d = in_random;
            // samples_q==0 marks the first sample of the run (no previous value)
            if (samples_q == '0)
                run_len_d = RUN_ONE;
            else if (in_random == prev_q)
                run_len_d = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + RUN_ONE;
            else
                run_len_d = RUN_ONE;
            if (run_len_d == RUN_MAX) stuck_d = 1'b1;
            prev_d = in_random;
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q        <= S_IDLE;
            issue_q        <= '0;
            count_q        <= '0;
            min_q          <= '0;
            max_q          <= '0;
            sample_valid_q <= 1'b0;
            range_errors_q <= '0;
            samples_q      <= '0;
            stuck_q        <= 1'b0;
            min_seen_q     <= '0;
            max_seen_q     <= '0;
            prev_q         <= '0;
            run_len_q      <= '0;
        end else begin
            state_q        <= state_d;
            issue_q        <= issue_d;
            count_q        <= count_d;
            min_q          <= min_d;
            max_q          <= max_d;
            sample_valid_q <= out_enable;
            range_errors_q <= range_errors_d;
            samples_q      <= samples_d;
            stuck_q        <= stuck_d;
            min_seen_q     <= min_seen_d;
            max_seen_q     <= max_seen_d;
            prev_q         <= prev_d;
            run_len_q      <= run_len_d;
        end
    end

    assign out_range_errors = range_errors_q;
    assign out_samples      = samples_q;
    assign out_stuck        = stuck_q;
    assign out_min_seen     = min_seen_q;
    assign out_max_seen     = max_seen_q;

endmodule

// File: tb/tb_rng_sample_checker.sv
// Directed bench for rng_sample_checker with a table-driven generator model.
module tb_rng_sample_checker;

    logic              in_clock = 1'b0;
    logic              in_reset = 1'b1;
    logic              in_start = 1'b0;
    logic signed [7:0] in_min   = '0;
    logic signed [7:0] in_max   = '0;
    logic [15:0]       in_count = '0;
    logic signed [7:0] in_random = '0;
    logic              out_enable, out_busy, out_done, out_stuck;
    logic [15:0]       out_range_errors, out_samples;
    logic signed [7:0] out_min_seen, out_max_seen;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [7:0] seq [256];
    int gidx = 0;

    rng_sample_checker #(.WIDTH(8), .COUNT_WIDTH(16), .STUCK_LIMIT(4)) dut (
        .in_clock(in_clock), .in_reset(in_reset), .in_start(in_start),
        .in_min(in_min), .in_max(in_max), .in_count(in_count),
        .in_random(in_random), .out_enable(out_enable), .out_busy(out_busy),
        .out_done(out_done), .out_range_errors(out_range_errors),
        .out_stuck(out_stuck), .out_min_seen(out_min_seen),
        .out_max_seen(out_max_seen), .out_samples(out_samples)
    );

    always #5 in_clock = ~in_clock;

    // generator model: registers the next table entry on every enabled edge
    always @(posedge in_clock) begin
        if (in_reset || out_done) gidx <= 0;
        else if (out_enable) begin
            in_random <= seq[gidx];
            gidx      <= gidx + 1;
        end
    end

    task automatic start_run(input logic signed [7:0] mn, input logic signed [7:0] mx,
                             input logic [15:0] cnt);
        @(negedge in_clock);
        in_start = 1'b1; in_min = mn; in_max = mx; in_count = cnt;
        @(negedge in_clock);
        in_start = 1'b0;
    endtask

    // cycle index counted from the start edge (1 = first cycle after it)
    task automatic wait_done(output int cyc, output int en_cyc);
        cyc = 1; en_cyc = 0;
        while (cyc < 400 && !out_done) begin
            if (out_enable) en_cyc++;
            @(negedge in_clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        int en_seen;
        en_seen = 0;
        in_reset = 1'b1; in_start = 1'b1; in_count = 16'd3;
        repeat (3) @(negedge in_clock);
        in_start = 1'b0;
        in_reset = 1'b0;
        repeat (5) begin
            @(negedge in_clock);
            if (out_enable || out_busy || out_done) en_seen++;
        end
        n_cmp++;
        if (en_seen !== 0) begin n_err++; $display("FAIL reset_idle_activity got %0d want 0", en_seen); end
        n_cmp++;
        if ({out_range_errors, out_samples, out_stuck, out_min_seen, out_max_seen} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got err=%0d smp=%0d stk=%0d min=%0d max=%0d want all 0",
                     out_range_errors, out_samples, out_stuck, out_min_seen, out_max_seen);
        end
    endtask

    task automatic test_ramp(input int n);
        int cyc, en;
        for (int i = 0; i < 256; i++) seq[i] = 8'(-10 + ((i + 1) % 21));
        start_run(-8'sd10, 8'sd10, 16'(n));
        wait_done(cyc, en);
        n_cmp++;
        if (cyc !== n + 2) begin n_err++; $display("FAIL ramp_done_cycle got %0d want %0d", cyc, n + 2); end
        n_cmp++;
        if (en !== n) begin n_err++; $display("FAIL ramp_enable_cycles got %0d want %0d", en, n); end
        n_cmp++;
        if (out_samples !== 16'(n) || out_range_errors !== 16'd0 || out_stuck !== 1'b0) begin
            n_err++;
            $display("FAIL ramp_stats got smp=%0d err=%0d stk=%0d want %0d 0 0",
                     out_samples, out_range_errors, out_stuck, n);
        end
        n_cmp++;
        if (out_min_seen !== -8'sd10 || out_max_seen !== 8'sd10) begin
            n_err++;
            $display("FAIL ramp_extremes got %0d..%0d want -10..10", out_min_seen, out_max_seen);
        end
        n_cmp++;
        if (out_busy !== 1'b1) begin n_err++; $display("FAIL ramp_busy_at_done got %b want 1", out_busy); end
        @(negedge in_clock);
        n_cmp++;
        if (out_busy !== 1'b0 || out_done !== 1'b0) begin
            n_err++; $display("FAIL ramp_after_done got busy=%b done=%b want 0 0", out_busy, out_done);
        end
    endtask

    task automatic test_range();
        int cyc, en;
        seq[0] = 8'sd5; seq[1] = 8'sd20; seq[2] = -8'sd11; seq[3] = 8'sd3;
        start_run(8'sd0, 8'sd10, 16'd4);
        // start while busy with different params must be ignored
        in_start = 1'b1; in_count = 16'd9; in_min = -8'sd100; in_max = 8'sd100;
        @(negedge in_clock);
        in_start = 1'b0;
        wait_done(cyc, en);
        cyc++;
        n_cmp++;
        if (cyc !== 6) begin n_err++; $display("FAIL range_done_cycle got %0d want 6", cyc); end
        n_cmp++;
        if (out_range_errors !== 16'd2 || out_samples !== 16'd4) begin
            n_err++; $display("FAIL range_errors got err=%0d smp=%0d want 2 4", out_range_errors, out_samples);
        end
        n_cmp++;
        if (out_min_seen !== -8'sd11 || out_max_seen !== 8'sd20) begin
            n_err++; $display("FAIL range_extremes got %0d..%0d want -11..20", out_min_seen, out_max_seen);
        end
    endtask

    task automatic test_stuck(input logic signed [7:0] last, input logic want);
        int cyc, en;
        seq[0] = 8'sd7; seq[1] = 8'sd7; seq[2] = 8'sd7; seq[3] = last;
        start_run(8'sd0, 8'sd10, 16'd4);
        wait_done(cyc, en);
        n_cmp++;
        if (out_stuck !== want) begin
            n_err++; $display("FAIL stuck_last_%0d got %b want %b", last, out_stuck, want);
        end
    endtask

    task automatic test_count_zero();
        int cyc, en;
        start_run(8'sd0, 8'sd10, 16'd0);
        wait_done(cyc, en);
        n_cmp++;
        if (cyc !== 1 || en !== 0) begin
            n_err++; $display("FAIL zero_done_cycle got cyc=%0d en=%0d want 1 0", cyc, en);
        end
        n_cmp++;
        if (out_samples !== 16'd0 || out_min_seen !== 8'sd127 || out_max_seen !== -8'sd128 || out_stuck !== 1'b0) begin
            n_err++;
            $display("FAIL zero_results got smp=%0d min=%0d max=%0d stk=%b want 0 127 -128 0",
                     out_samples, out_min_seen, out_max_seen, out_stuck);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, en;
        seq[0] = 8'sd1; seq[1] = 8'sd2;
        start_run(8'sd0, 8'sd10, 16'd2);
        wait_done(cyc, en);
        seq[0] = 8'sd9; seq[1] = 8'sd9; seq[2] = 8'sd4;
        // start_run raises start in the first IDLE cycle after DONE
        start_run(8'sd5, 8'sd10, 16'd3);
        wait_done(cyc, en);
        n_cmp++;
        if (cyc !== 5 || out_samples !== 16'd3 || out_range_errors !== 16'd1) begin
            n_err++;
            $display("FAIL b2b_second_run got cyc=%0d smp=%0d err=%0d want 5 3 1", cyc, out_samples, out_range_errors);
        end
        n_cmp++;
        if (out_min_seen !== 8'sd4 || out_max_seen !== 8'sd9) begin
            n_err++; $display("FAIL b2b_extremes got %0d..%0d want 4..9", out_min_seen, out_max_seen);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, dones;
        dones = 0;
        for (int i = 0; i < 256; i++) seq[i] = 8'(-10 + ((i + 1) % 21));
        start_run(-8'sd10, 8'sd10, 16'd100);
        cyc = 1;
        while (cyc < 50) begin @(negedge in_clock); cyc++; end
        in_reset = 1'b1;
        @(negedge in_clock);
        n_cmp++;
        if (out_enable !== 1'b0 || out_busy !== 1'b0 || out_samples !== 16'd0) begin
            n_err++;
            $display("FAIL midreset_outputs got en=%b busy=%b smp=%0d want 0 0 0", out_enable, out_busy, out_samples);
        end
        in_reset = 1'b0;
        repeat (6) begin
            @(negedge in_clock);
            if (out_done || out_enable) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin n_err++; $display("FAIL midreset_no_done got %0d want 0", dones); end
        test_ramp(100);
    endtask

    initial begin
        test_reset();
        test_ramp(200);
        test_range();
        test_stuck(8'sd7, 1'b1);
        test_stuck(8'sd8, 1'b0);
        test_count_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
